// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and digit helper for the serial packed-BCD adder.
package bcd_pkg;

    localparam int BCD_W   = 4;
    localparam int BCD_MAX = 9;
    localparam int BCD_ADJ = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    function automatic logic digit_invalid(input logic [BCD_W-1:0] d);
        return d > BCD_W'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Operand/request and result bundle between the operand source and the BCD add controller.
interface bcd_serial_add_ctrl_if
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
);

    logic                    start;
    logic [BCD_W*DIGITS-1:0] a_bcd;
    logic [BCD_W*DIGITS-1:0] b_bcd;
    logic                    cin;
    logic                    busy;
    logic                    done;
    logic [BCD_W*DIGITS-1:0] sum;
    logic                    cout;
    logic                    err;

    modport master (
        output start, a_bcd, b_bcd, cin,
        input  busy, done, sum, cout, err
    );

    modport slave (
        input  start, a_bcd, b_bcd, cin,
        output busy, done, sum, cout, err
    );

endinterface

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder; invalid digits go through the same +6 rule unchanged.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] a,
    input  logic [BCD_W-1:0] b,
    input  logic             cin,
    output logic [BCD_W-1:0] result,
    output logic             cout
);

    localparam int SW = BCD_W + 1;

    logic [SW-1:0] s;

    always_comb begin
        s = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
        if (s > SW'(BCD_MAX)) begin
            // Truncation to BCD_W bits gives the mod-16 wrap after the +6 adjust.
            result = s[BCD_W-1:0] + BCD_W'(BCD_ADJ);
            cout   = 1'b1;
        end else begin
            result = s[BCD_W-1:0];
            cout   = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: one shared digit adder, LSD first, carry rippled through a register.
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_serial_add_ctrl_if.slave  bus
);

    localparam int W     = BCD_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

    state_t           state;
    logic [W-1:0]     a_sr;
    logic [W-1:0]     b_sr;
    logic [W-1:0]     sum_q;
    logic [IDX_W-1:0] idx;
    logic             carry_q;
    logic             cout_q;
    logic             err_q;
    logic             busy_q;
    logic             done_q;

    logic [BCD_W-1:0] dig_res;
    logic             dig_cout;

    // Operands shift right each RUN cycle so the current digit is always at the bottom.
    bcd_digit_add u_digit_add (
        .a      (a_sr[BCD_W-1:0]),
        .b      (b_sr[BCD_W-1:0]),
        .cin    (carry_q),
        .result (dig_res),
        .cout   (dig_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            sum_q   <= '0;
            idx     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sr    <= bus.a_bcd;
                        b_sr    <= bus.b_bcd;
                        carry_q <= bus.cin;
                        idx     <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx*BCD_W +: BCD_W] <= dig_res;
                    carry_q <= dig_cout;
                    err_q   <= err_q | digit_invalid(a_sr[BCD_W-1:0])
                                     | digit_invalid(b_sr[BCD_W-1:0]);
                    a_sr    <= a_sr >> BCD_W;
                    b_sr    <= b_sr >> BCD_W;
                    if (idx == LAST) begin
                        cout_q <= dig_cout;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl with hand-computed packed-BCD results (DIGITS=4).
module tb_bcd_serial_add_ctrl;

    localparam int DIGITS = 4;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after a rising edge; pulses start for one cycle and follows the op to IDLE.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic [15:0] es, input logic ec, input logic ee);
        int n;
        bus.a_bcd = a;
        bus.b_bcd = b;
        bus.cin   = ci;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk({tag, "_busy_at_accept"}, 32'(bus.busy), 32'd1);
        chk({tag, "_sum_cleared"},    32'(bus.sum),  32'h0);
        chk({tag, "_err_cleared"},    32'(bus.err),  32'd0);
        n = 0;
        while (!bus.done && n < 20) begin
            step();
            n = n + 1;
        end
        chk({tag, "_latency"}, 32'(n),        32'(DIGITS));
        chk({tag, "_sum"},     32'(bus.sum),  32'(es));
        chk({tag, "_cout"},    32'(bus.cout), 32'(ec));
        chk({tag, "_err"},     32'(bus.err),  32'(ee));
        step();
        chk({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
        chk({tag, "_busy_after"},     32'(bus.busy), 32'd0);
        chk({tag, "_sum_hold"},       32'(bus.sum),  32'(es));
    endtask

    initial begin
        int dcount;
        int doff1;
        int doff2;
        logic [15:0] dsum1;
        logic [15:0] dsum2;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a_bcd = '0;
        bus.b_bcd = '0;
        bus.cin   = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum",  32'(bus.sum),  32'h0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_err",  32'(bus.err),  32'd0);
        rst = 1'b0;
        step();

        run_op("add_7_8",       16'h0007, 16'h0008, 1'b0, 16'h0015, 1'b0, 1'b0);
        run_op("add_9999_1",    16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_0999_cin",  16'h0999, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0);
        run_op("add_9_9",       16'h0009, 16'h0009, 1'b0, 16'h0018, 1'b0, 1'b0);
        repeat (3) step();
        chk("idle_hold_sum", 32'(bus.sum), 32'h0018);
        run_op("add_5_4",       16'h0005, 16'h0004, 1'b0, 16'h0009, 1'b0, 1'b0);

        // start held high with operands changing every cycle
        bus.a_bcd = 16'h1234;
        bus.b_bcd = 16'h4321;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        step();
        dcount = 0;
        doff1  = -1;
        doff2  = -1;
        dsum1  = '0;
        dsum2  = '0;
        for (int k = 1; k <= 12; k++) begin
            bus.a_bcd = (k == 1) ? 16'h8888 : 16'h7000 + 16'(k);
            bus.b_bcd = 16'h0777;
            step();
            if (bus.done) begin
                dcount = dcount + 1;
                if (doff1 < 0) begin
                    doff1 = k;
                    dsum1 = bus.sum;
                end else begin
                    doff2 = k;
                    dsum2 = bus.sum;
                end
            end
            if (k == 5) begin
                bus.a_bcd = 16'h2000;
                bus.b_bcd = 16'h0022;
                step();
                k = k + 1;
            end
            if (k == 10) bus.start = 1'b0;
        end
        chk("held_done_count", 32'(dcount), 32'd2);
        chk("held_done_off1",  32'(doff1),  32'd4);
        chk("held_done_off2",  32'(doff2),  32'd10);
        chk("held_sum1",       32'(dsum1),  32'h5555);
        chk("held_sum2",       32'(dsum2),  32'h2022);

        // reset in the second RUN cycle aborts the operation
        step();
        bus.a_bcd = 16'h1234;
        bus.b_bcd = 16'h1111;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_sum",  32'(bus.sum),  32'h0);
        chk("abort_cout", 32'(bus.cout), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        dcount = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (bus.done) dcount = dcount + 1;
        end
        chk("abort_no_done", 32'(dcount), 32'd0);
        run_op("after_abort",   16'h0042, 16'h0058, 1'b0, 16'h0100, 1'b0, 1'b0);

        run_op("invalid_digit", 16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1);
        run_op("err_clears",    16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
